// File: rtl/sub_word_store_unit_if.sv
// Store-unit bus: MEM-stage store request/handshake plus the word-wide data RAM port.
//   master: store requester and RAM model (drives req_*, mem_rdata)
//   slave : sub_word_store_unit (drives req_ready, mem_* strobes/addr/wdata, done, err)
interface sub_word_store_unit_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_addr;
    logic [31:0]       req_data;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [31:0]       mem_rdata;
    logic              mem_wr_en;
    logic [31:0]       mem_wdata;
    logic              done;
    logic              err;

    modport master (
        output req_valid, req_addr, req_data, req_size, mem_rdata,
        input  req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, done, err
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_size, mem_rdata,
        output req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, done, err
    );
endinterface

// File: rtl/sub_word_store_unit.sv
// Store-side narrowing unit: writes byte/half/word stores into a word RAM with no
// byte enables, using read-modify-write for sub-word sizes.
//   clk, reset : system clock, asynchronous active-high reset
//   bus.req_*  : store request (valid/ready, byte address, rt data, size 0/1/2)
//   bus.mem_*  : word RAM port (one-cycle read latency, full-word write)
//   bus.done   : pulse with the RAM write; bus.err : pulse for an illegal request
module sub_word_store_unit #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    sub_word_store_unit_if.slave bus
);
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {IDLE, RD, WR, ERR} state_t;

    state_t      state;
    logic [1:0]  off_q;
    logic [31:0] data_q;
    logic [1:0]  size_q;
    logic        accept;
    logic        illegal;
    logic [31:0] merged;
    logic        unused_addr_hi;

    // Only the word address and byte offset matter; upper address bits wrap away.
    assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];

    assign bus.req_ready = (state == IDLE);
    assign accept        = bus.req_valid && (state == IDLE);

    // Natural-alignment check on the incoming request.
    always_comb begin
        illegal = 1'b0;
        case (bus.req_size)
            SZ_BYTE: illegal = 1'b0;
            SZ_HALF: illegal = bus.req_addr[0];
            SZ_WORD: illegal = (bus.req_addr[1:0] != 2'b00);
            default: illegal = 1'b1;
        endcase
    end

    // Control FSM with registered strobes and word address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            off_q         <= 2'd0;
            data_q        <= 32'd0;
            size_q        <= 2'd0;
            bus.mem_addr  <= '0;
            bus.mem_rd_en <= 1'b0;
            bus.mem_wr_en <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        off_q  <= bus.req_addr[1:0];
                        data_q <= bus.req_data;
                        size_q <= bus.req_size;
                        if (illegal) begin
                            state   <= ERR;
                            bus.err <= 1'b1;
                        end else if (bus.req_size == SZ_WORD) begin
                            state         <= WR;
                            bus.mem_addr  <= bus.req_addr[ADDR_W+1:2];
                            bus.mem_wr_en <= 1'b1;
                            bus.done      <= 1'b1;
                        end else begin
                            state         <= RD;
                            bus.mem_addr  <= bus.req_addr[ADDR_W+1:2];
                            bus.mem_rd_en <= 1'b1;
                        end
                    end
                end
                RD: begin
                    state         <= WR;
                    bus.mem_rd_en <= 1'b0;
                    bus.mem_wr_en <= 1'b1;
                    bus.done      <= 1'b1;
                end
                WR, ERR: begin
                    state         <= IDLE;
                    bus.mem_addr  <= '0;
                    bus.mem_wr_en <= 1'b0;
                    bus.done      <= 1'b0;
                    bus.err       <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Merge the narrowed field into the word read back during RD.
    always_comb begin
        merged = bus.mem_rdata;
        case (size_q)
            SZ_BYTE: begin
                case (off_q)
                    2'd0:    merged[7:0]   = data_q[7:0];
                    2'd1:    merged[15:8]  = data_q[7:0];
                    2'd2:    merged[23:16] = data_q[7:0];
                    default: merged[31:24] = data_q[7:0];
                endcase
            end
            SZ_HALF: begin
                if (off_q[1]) merged[31:16] = data_q[15:0];
                else          merged[15:0]  = data_q[15:0];
            end
            default: merged = data_q;
        endcase
        bus.mem_wdata = (state == WR) ? merged : 32'd0;
    end
endmodule

// File: tb/tb_sub_word_store_unit.sv
// Bench for sub_word_store_unit: directed vector table, reset-abort and back-to-back
// sequences, then random stores checked against a byte-lane memory model.
module tb_sub_word_store_unit;
    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned RAM_WORDS = 1 << ADDR_W;
    localparam int unsigned N_VECS    = 12;
    localparam int unsigned N_RAND    = 300;

    logic clk = 1'b0;
    logic reset;
    logic ram_clr;
    always #5 clk = ~clk;

    sub_word_store_unit_if #(.ADDR_W(ADDR_W)) bus ();

    sub_word_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Synchronous word RAM, one-cycle read latency.
    logic [31:0] ram     [RAM_WORDS];
    logic [31:0] ref_mem [RAM_WORDS];
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < int'(RAM_WORDS); i++) ram[i] <= 32'(i) * 32'h9E37_79B1;
        end else begin
            if (bus.mem_rd_en) bus.mem_rdata <= ram[bus.mem_addr];
            if (bus.mem_wr_en) ram[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    int wr_cnt   = 0;
    int done_cnt = 0;
    always @(posedge clk) begin
        if (bus.mem_wr_en) wr_cnt <= wr_cnt + 1;
        if (bus.done)      done_cnt <= done_cnt + 1;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // {req_ready, mem_rd_en, mem_wr_en, done, err}
    function automatic logic [4:0] sig();
        return {bus.req_ready, bus.mem_rd_en, bus.mem_wr_en, bus.done, bus.err};
    endfunction

    localparam logic [4:0] S_IDLE = 5'b10000;
    localparam logic [4:0] S_RD   = 5'b01000;
    localparam logic [4:0] S_WR   = 5'b00110;
    localparam logic [4:0] S_ERR  = 5'b00001;
    localparam logic [4:0] S_OFF  = 5'b10000;

    // Reference: a store of 2**size bytes at byte offset off must be naturally aligned.
    function automatic logic model_legal(input logic [1:0] sz, input logic [1:0] off);
        int n;
        if (sz == 2'd3) return 1'b0;
        n = 1 << sz;
        return (int'(off) % n) == 0;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] old, input logic [1:0] sz,
                                                input logic [1:0] off, input logic [31:0] d);
        logic [31:0] r;
        int n;
        int b;
        r = old;
        n = 1 << sz;
        for (int j = 0; j < n; j++) begin
            b = int'(off) + j;
            r[8*b +: 8] = d[8*j +: 8];
        end
        return r;
    endfunction

    // Issue one store at a negedge in IDLE and check every cycle until back in IDLE.
    task automatic do_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                            input logic exp_err, input logic [31:0] exp_wdata, input string name);
        logic [ADDR_W-1:0] w;
        w = a[ADDR_W+1:2];
        check32({name, ".idle"}, 32'(sig()), 32'(S_IDLE));
        bus.req_valid = 1'b1;
        bus.req_size  = sz;
        bus.req_addr  = a;
        bus.req_data  = d;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
        bus.req_data  = $urandom;
        bus.req_size  = 2'($urandom_range(0, 3));
        if (exp_err) begin
            check32({name, ".err"}, 32'(sig()), 32'(S_ERR));
            check32({name, ".err_addr"}, 32'(bus.mem_addr), 32'd0);
        end else begin
            if (sz != 2'd2) begin
                check32({name, ".rd"}, 32'(sig()), 32'(S_RD));
                check32({name, ".rd_addr"}, 32'(bus.mem_addr), 32'(w));
                @(negedge clk);
            end
            check32({name, ".wr"}, 32'(sig()), 32'(S_WR));
            check32({name, ".wr_addr"}, 32'(bus.mem_addr), 32'(w));
            check32({name, ".wdata"}, bus.mem_wdata, exp_wdata);
            ref_mem[w] = exp_wdata;
        end
        @(negedge clk);
        check32({name, ".after"}, 32'(sig()), 32'(S_IDLE));
        check32({name, ".ram"}, ram[w], ref_mem[w]);
    endtask

    typedef struct {
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
        logic        exp_err;
        logic [31:0] exp_wdata;
        string       name;
    } vec_t;

    vec_t vecs [N_VECS];

    initial begin
        int wr0;
        int done0;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] d;
        logic [ADDR_W-1:0] w;
        logic        lg;

        vecs[0]  = '{2'd2, 32'h0000_0010, 32'hAABB_CCDD, 1'b0, 32'hAABB_CCDD, "pre_sw_a"};
        vecs[1]  = '{2'd0, 32'h0000_0012, 32'h1122_3344, 1'b0, 32'hAA44_CCDD, "sb_0x12"};
        vecs[2]  = '{2'd2, 32'h0000_0010, 32'hAABB_CCDD, 1'b0, 32'hAABB_CCDD, "pre_sw_b"};
        vecs[3]  = '{2'd1, 32'h0000_0012, 32'h0000_BEEF, 1'b0, 32'hBEEF_CCDD, "sh_0x12"};
        vecs[4]  = '{2'd2, 32'h0000_0010, 32'hAABB_CCDD, 1'b0, 32'hAABB_CCDD, "pre_sw_c"};
        vecs[5]  = '{2'd1, 32'h0000_0010, 32'h0000_BEEF, 1'b0, 32'hAABB_BEEF, "sh_0x10"};
        vecs[6]  = '{2'd2, 32'h0000_0010, 32'h1234_5678, 1'b0, 32'h1234_5678, "sw_0x10"};
        vecs[7]  = '{2'd1, 32'h0000_0013, 32'h0000_BEEF, 1'b1, 32'h0,         "sh_misal"};
        vecs[8]  = '{2'd2, 32'h0000_0012, 32'h1234_5678, 1'b1, 32'h0,         "sw_misal"};
        vecs[9]  = '{2'd3, 32'h0000_0010, 32'h1234_5678, 1'b1, 32'h0,         "size3"};
        vecs[10] = '{2'd0, 32'h0000_0013, 32'h0000_00FF, 1'b0, 32'hFF34_5678, "sb_lane3"};
        vecs[11] = '{2'd2, 32'hFFFF_F010, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, "sw_wrap"};

        for (int i = 0; i < int'(RAM_WORDS); i++) ref_mem[i] = 32'(i) * 32'h9E37_79B1;

        // Reset: ready reads 1 but requests are ignored.
        reset         = 1'b1;
        ram_clr       = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_size  = 2'd2;
        bus.req_addr  = 32'h10;
        bus.req_data  = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        check32("reset.sig", 32'(sig()), 32'(S_IDLE));
        check32("reset.addr", 32'(bus.mem_addr), 32'd0);
        check32("reset.wdata", bus.mem_wdata, 32'd0);
        bus.req_valid = 1'b0;
        ram_clr       = 1'b0;
        reset         = 1'b0;
        @(negedge clk);
        check32("reset.nowrite", ram[4], ref_mem[4]);

        for (int i = 0; i < int'(N_VECS); i++)
            do_store(vecs[i].size, vecs[i].addr, vecs[i].data, vecs[i].exp_err,
                     vecs[i].exp_wdata, vecs[i].name);

        // Reset raised during RD aborts the store.
        wr0   = wr_cnt;
        done0 = done_cnt;
        bus.req_valid = 1'b1;
        bus.req_size  = 2'd0;
        bus.req_addr  = 32'h10;
        bus.req_data  = 32'h77;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check32("abort.rd", 32'(sig()), 32'(S_RD));
        #2 reset = 1'b1;
        #1;
        check32("abort.strobes", 32'(sig()), 32'(S_OFF));
        check32("abort.addr", 32'(bus.mem_addr), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check32("abort.wr_cnt", 32'(wr_cnt), 32'(wr0));
        check32("abort.done_cnt", 32'(done_cnt), 32'(done0));
        check32("abort.ready", 32'(sig()), 32'(S_IDLE));
        check32("abort.ram", ram[4], ref_mem[4]);

        // Back-to-back byte stores with req_valid held high.
        do_store(2'd2, 32'h10, 32'h0, 1'b0, 32'h0, "b2b_clear");
        bus.req_valid = 1'b1;
        bus.req_size  = 2'd0;
        bus.req_addr  = 32'h10;
        bus.req_data  = 32'h55;
        @(negedge clk);
        check32("b2b.rd1", 32'(sig()), 32'(S_RD));
        bus.req_addr = 32'h11;
        bus.req_data = 32'h66;
        @(negedge clk);
        check32("b2b.wr1", 32'(sig()), 32'(S_WR));
        check32("b2b.wdata1", bus.mem_wdata, 32'h0000_0055);
        @(negedge clk);
        check32("b2b.ready", 32'(sig()), 32'(S_IDLE));
        @(negedge clk);
        bus.req_valid = 1'b0;
        check32("b2b.rd2", 32'(sig()), 32'(S_RD));
        @(negedge clk);
        check32("b2b.wr2", 32'(sig()), 32'(S_WR));
        check32("b2b.wdata2", bus.mem_wdata, 32'h0000_6655);
        @(negedge clk);
        check32("b2b.idle", 32'(sig()), 32'(S_IDLE));
        check32("b2b.ram", ram[4], 32'h0000_6655);
        ref_mem[4] = 32'h0000_6655;

        // Random stores against the byte-lane model.
        for (int i = 0; i < int'(N_RAND); i++) begin
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 1) == 1) a[11:4] = 8'd0;
            d  = $urandom;
            w  = a[ADDR_W+1:2];
            lg = model_legal(sz, a[1:0]);
            do_store(sz, a, d, !lg, lg ? model_store(ref_mem[w], sz, a[1:0], d) : 32'h0,
                     $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
